freq_word_editor: RTL and testbench
===================================

// Module: freq_word_editor
// PURPOSE
// Keypad-driven editor for NCHAN frequency tuning words (AD9837 FREQ0/FREQ1 and wider DDS parts).
// Debounces raw active-low KEYS, moves a hex-digit cursor, and increments/decrements the selected
// digit of the active channel's word. Drives digit-select/blink masks for the hex SSD decoder.
// Offers each changed word to the SPI writer over a coalescing valid/ready handshake.
// PARAMETERS
// WIDTH      28        tuning word width in bits
// NDIG       7         editable hex digits, = ceil(WIDTH/4)
// NCHAN      2         number of frequency words (channels)
// CW         1         channel index width, = max(1,clog2(NCHAN))
// DEB_CYC    50000     cycles a key must be stable before its new level is accepted
// BLINK_DIV  12500000  cycles per half-period of the cursor blink
// CARRY      1         1: +/-16^cursor on the whole word, mod 2^WIDTH; 0: selected nibble wraps alone
// RST_WORD   0         reset value of every channel word
// PORTS
// clk        in   1            system clock
// rst_n      in   1            asynchronous active-low reset
// KEYS       in   4            raw keys, active low: [0] inc, [1] dec, [2] cursor left, [3] next channel
// FREQ       out  NCHAN*WIDTH  all words, channel c at [c*WIDTH +: WIDTH]
// chan_sel   out  CW           active channel
// act_word   out  WIDTH        word of the active channel (feeds hex_ssd)
// digit_sel  out  NDIG         one-hot cursor, bit 0 = least significant nibble
// digit_en   out  NDIG         per-digit display enable; blinks the cursor digit
// upd_valid  out  1            pending word for SPI writer
// upd_chan   out  CW           channel of pending word
// upd_word   out  WIDTH        pending word value
// upd_ready  in   1            SPI writer accepts when upd_valid & upd_ready at a clock edge
// BEHAVIOUR
// - Reset (async, rst_n=0): all words = RST_WORD, chan_sel=0, digit_sel=1, digit_en=all 1,
//   upd_valid=0, upd_chan=0, upd_word=0, debounce state = released, blink phase 0.
// - Debounce per key: 2-flop sync, then a counter that restarts on every raw change. When the raw level
//   has been stable DEB_CYC cycles it is accepted. A released->pressed transition gives a 1-cycle press pulse.
//   A release or a glitch shorter than DEB_CYC produces nothing.
// - Several press pulses in one cycle: only the highest-priority one acts (KEYS[0] > [1] > [2] > [3]).
//   The others are dropped.
// - Edit latency: a press pulse in cycle t updates its register on the edge ending cycle t.
//   The register is the word, cursor or channel. Outputs are registered; no extra pipeline stages.
// - inc/dec, CARRY=1: word +/- (1<<4*k), k = cursor index, result mod 2^WIDTH.
// - inc/dec, CARRY=0: only nibble k changes, 4'hF+1->0 and 0-1->4'hF.
//   If WIDTH%4 != 0, the top nibble is masked to its valid bits.
// - Cursor left: digit_sel rotates left; bit NDIG-1 wraps to bit 0.
// - Next channel: chan_sel+1, NCHAN-1 wraps to 0. Cursor is kept. No update is queued.
// - Every inc/dec loads upd_chan/upd_word with the new value and sets upd_valid on the same edge.
// - Handshake: upd_valid stays high until an edge with upd_ready=1. On that edge it clears,
//   unless an edit fires on the same edge; then valid stays high with the new data (the edit wins).
// - Coalescing: an edit while valid is pending overwrites chan/word, so one transfer carries the latest.
//   An edit to another channel also overwrites, so the SPI writer sees only the last channel.
//   upd_word/upd_chan are stable while valid=1 and ready=0, except when overwritten by a new edit.
// - Blink: counter wraps every BLINK_DIV cycles and toggles phase.
//   digit_en = phase ? ~digit_sel : all 1.
// - Reset mid-handshake discards the pending update. Edits are never issued while rst_n=0.
// TESTING (DEB_CYC=4, BLINK_DIV=8 in sim)
// 1 Release rst_n -> FREQ=0, digit_sel=7'b0000001, upd_valid=0; digit_en toggles 0x7F/0x7E every 8 cycles.
// 2 KEYS[0] low 3 cycles -> no change. Low 10 cycles -> act_word=0x0000001, upd_valid=1, upd_word=1, upd_chan=0.
// 3 KEYS[2] x2, KEYS[0] -> act_word 0x0000101. KEYS[1] x2, CARRY=1 -> 0xFFFFF01. CARRY=0 -> 0x0000F01.
// 4 upd_ready=0, 3 increments at digit 0 -> upd_valid held, upd_word=3; ready=1 -> one transfer, valid=0.
// 5 KEYS[3] then inc -> chan_sel=1, FREQ[55:28]=1, FREQ[27:0] unchanged, upd_chan=1.
//   KEYS[2] x7 -> digit_sel back to 1.
// 6 Press KEYS[0] and KEYS[1] together -> only +1 applied. rst_n=0 while upd_valid=1 -> valid=0, words=RST_WORD.

Source files
------------

// File: rtl/freq_word_editor.sv
`default_nettype none
// ============================================================================
//  Module      : freq_word_editor
//  Description : Keypad-driven editor for NCHAN frequency tuning words.
//                Debounces four raw active-low keys, moves a hex-digit
//                cursor, increments/decrements the selected digit of the
//                active channel's word, drives digit select / blink masks
//                for a hex seven-segment decoder and offers every edited
//                word to an SPI writer over a coalescing valid/ready
//                handshake.
//  Ports       : clk        system clock
//                rst_n      asynchronous active-low reset
//                KEYS[3:0]  raw keys, active low: 0 inc, 1 dec,
//                           2 cursor left, 3 next channel
//                FREQ       all words, channel c at [c*WIDTH +: WIDTH]
//                chan_sel   active channel
//                act_word   word of the active channel
//                digit_sel  one-hot cursor, bit 0 = least significant nibble
//                digit_en   per-digit display enable (cursor digit blinks)
//                upd_valid  pending word for the SPI writer
//                upd_chan   channel of the pending word
//                upd_word   value of the pending word
//                upd_ready  SPI writer accepts on valid & ready at an edge
//  Revision    : 1.0  initial release
// ============================================================================
module freq_word_editor #(
    parameter int               WIDTH     = 28,
    parameter int               NDIG      = 7,
    parameter int               NCHAN     = 2,
    parameter int               CW        = 1,
    parameter int               DEB_CYC   = 50000,
    parameter int               BLINK_DIV = 12500000,
    parameter int               CARRY     = 1,
    parameter logic [WIDTH-1:0] RST_WORD  = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3:0]             KEYS,
    output logic [NCHAN*WIDTH-1:0] FREQ,
    output logic [CW-1:0]          chan_sel,
    output logic [WIDTH-1:0]       act_word,
    output logic [NDIG-1:0]        digit_sel,
    output logic [NDIG-1:0]        digit_en,
    output logic                   upd_valid,
    output logic [CW-1:0]          upd_chan,
    output logic [WIDTH-1:0]       upd_word,
    input  logic                   upd_ready
);

    localparam int DCW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int BW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int IW  = (NDIG > 1) ? $clog2(NDIG) : 1;

    // ------------------------------------------------------------------
    // Key synchronisers. Reset to '1' so that every key starts released.
    // ------------------------------------------------------------------
    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] w_press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
        end else begin
            r_sync1 <= KEYS;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Per-key debounce. The counter only runs while the synchronised level
    // differs from the accepted level, so any return to the accepted level
    // (a glitch) restarts it. A new pressed level yields a one-cycle pulse.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < 4; k++) begin : g_deb
        logic [DCW-1:0] r_cnt;
        logic           r_stable;
        logic           r_pulse;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt    <= '0;
                r_stable <= 1'b1;
                r_pulse  <= 1'b0;
            end else begin
                r_pulse <= 1'b0;
                if (r_sync2[k] == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == DCW'(DEB_CYC - 1)) begin
                    r_cnt    <= '0;
                    r_stable <= r_sync2[k];
                    r_pulse  <= ~r_sync2[k];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_press[k] = r_pulse;
    end

    // Fixed priority: inc > dec > cursor left > next channel.
    logic w_inc;
    logic w_dec;
    logic w_left;
    logic w_next;
    logic w_edit;

    assign w_inc  = w_press[0];
    assign w_dec  = w_press[1] & ~w_press[0];
    assign w_left = w_press[2] & ~(|w_press[1:0]);
    assign w_next = w_press[3] & ~(|w_press[2:0]);
    assign w_edit = w_inc | w_dec;

    // ------------------------------------------------------------------
    // Editable state
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_word [NCHAN];
    logic [CW-1:0]    r_chan;
    logic [IW-1:0]    r_cur;

    // Edit arithmetic. The step is one unit of the selected nibble. With
    // CARRY=0 the sum is masked back into the selected nibble: since the
    // step has no bits below the nibble, the masked sum is the nibble
    // itself +/-1 wrapped, and the mask truncation to WIDTH handles a
    // partial top nibble for free.
    logic [WIDTH-1:0] w_cur_word;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_nmask;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_new;

    assign w_cur_word = r_word[r_chan];
    assign w_step     = {{(WIDTH-1){1'b0}}, 1'b1} << {r_cur, 2'b00};
    assign w_nmask    = {{(WIDTH-1){1'b0}}, 1'b1} << {r_cur, 2'b00};

    always_comb begin
        w_sum = w_cur_word + w_step;
        if (w_dec) begin
            w_sum = w_cur_word - w_step;
        end
        w_new = w_sum;
        if (CARRY == 0) begin
            w_new = (w_cur_word & ~(w_nmask * WIDTH'(15))) | (w_sum & (w_nmask * WIDTH'(15)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCHAN; c++) begin
                r_word[c] <= RST_WORD;
            end
        end else if (w_edit) begin
            r_word[r_chan] <= w_new;
        end
    end

    // Channel select and cursor index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chan <= '0;
            r_cur  <= '0;
        end else begin
            if (w_next) begin
                r_chan <= (r_chan == CW'(NCHAN - 1)) ? '0 : r_chan + 1'b1;
            end
            if (w_left) begin
                r_cur <= (r_cur == IW'(NDIG - 1)) ? '0 : r_cur + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Update handshake. A fresh edit always wins over an acceptance on
    // the same edge, so the newest value is never lost.
    // ------------------------------------------------------------------
    logic             r_upd_valid;
    logic [CW-1:0]    r_upd_chan;
    logic [WIDTH-1:0] r_upd_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upd_valid <= 1'b0;
            r_upd_chan  <= '0;
            r_upd_word  <= '0;
        end else if (w_edit) begin
            r_upd_valid <= 1'b1;
            r_upd_chan  <= r_chan;
            r_upd_word  <= w_new;
        end else if (upd_ready) begin
            r_upd_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Cursor blink
    // ------------------------------------------------------------------
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_ph;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
        end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_blink_ph  <= ~r_blink_ph;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all decoded straight from registers)
    // ------------------------------------------------------------------
    for (genvar c = 0; c < NCHAN; c++) begin : g_pack
        assign FREQ[c*WIDTH +: WIDTH] = r_word[c];
    end

    assign chan_sel  = r_chan;
    assign act_word  = w_cur_word;
    assign digit_sel = {{(NDIG-1){1'b0}}, 1'b1} << r_cur;
    assign digit_en  = r_blink_ph ? ~digit_sel : {NDIG{1'b1}};
    assign upd_valid = r_upd_valid;
    assign upd_chan  = r_upd_chan;
    assign upd_word  = r_upd_word;

endmodule
`default_nettype wire

// File: tb/tb_freq_word_editor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_freq_word_editor
//  Description : Self-checking bench for freq_word_editor. Two instances
//                (CARRY=1 and CARRY=0) share the same stimulus; a
//                behavioural model predicts all outputs every cycle and a
//                few hand-computed literals pin the model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_freq_word_editor;

    localparam int W   = 28;
    localparam int ND  = 7;
    localparam int NC  = 2;
    localparam int DEB = 4;
    localparam int BLK = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] keys;
    logic       upd_ready;

    logic [NC*W-1:0] freq1, freq0;
    logic [0:0]      chan1, chan0, uchan1, uchan0;
    logic [W-1:0]    act1, act0, uword1, uword0;
    logic [ND-1:0]   dsel1, dsel0, den1, den0;
    logic            uval1, uval0;

    always #5 clk = ~clk;

    freq_word_editor #(.WIDTH(W), .NDIG(ND), .NCHAN(NC), .CW(1), .DEB_CYC(DEB),
                       .BLINK_DIV(BLK), .CARRY(1), .RST_WORD('0)) u_dut_c1 (
        .clk(clk), .rst_n(rst_n), .KEYS(keys), .FREQ(freq1), .chan_sel(chan1),
        .act_word(act1), .digit_sel(dsel1), .digit_en(den1), .upd_valid(uval1),
        .upd_chan(uchan1), .upd_word(uword1), .upd_ready(upd_ready));

    freq_word_editor #(.WIDTH(W), .NDIG(ND), .NCHAN(NC), .CW(1), .DEB_CYC(DEB),
                       .BLINK_DIV(BLK), .CARRY(0), .RST_WORD('0)) u_dut_c0 (
        .clk(clk), .rst_n(rst_n), .KEYS(keys), .FREQ(freq0), .chan_sel(chan0),
        .act_word(act0), .digit_sel(dsel0), .digit_en(den0), .upd_valid(uval0),
        .upd_chan(uchan0), .upd_word(uword0), .upd_ready(upd_ready));

    int n_tests = 0;
    int n_fail  = 0;
    int n_xfer  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [3:0] m_s1, m_s2, m_last, m_acc, m_press;
    int         m_run [4];
    logic [W-1:0] m_w1 [NC];
    logic [W-1:0] m_w0 [NC];
    int         m_chan, m_cur, m_n;
    logic       m_val;
    int         m_uchan;
    logic [W-1:0] m_uw1, m_uw0;

    function automatic logic [W-1:0] nib_edit(input logic [W-1:0] w, input int k, input bit up);
        logic [3:0]   nib;
        logic [W-1:0] msk;
        nib = 4'((w >> (4*k)) & 28'hF);
        nib = up ? nib + 4'd1 : nib - 4'd1;
        msk = 28'hF << (4*k);
        return (w & ~msk) | (W'(nib) << (4*k));
    endfunction

    task automatic model_reset();
        m_s1 = 4'hF; m_s2 = 4'hF; m_last = 4'hF; m_acc = 4'hF; m_press = 4'h0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        for (int c = 0; c < NC; c++) begin m_w1[c] = '0; m_w0[c] = '0; end
        m_chan = 0; m_cur = 0; m_n = 0;
        m_val = 1'b0; m_uchan = 0; m_uw1 = '0; m_uw0 = '0;
    endtask

    task automatic model_step();
        logic [3:0]   np;
        logic [W-1:0] step;
        bit           edit;
        edit = 1'b0;
        step = W'(1) << (4*m_cur);
        if (m_press[0] || m_press[1]) begin
            edit = 1'b1;
            if (m_press[0]) begin
                m_w1[m_chan] = m_w1[m_chan] + step;
                m_w0[m_chan] = nib_edit(m_w0[m_chan], m_cur, 1'b1);
            end else begin
                m_w1[m_chan] = m_w1[m_chan] - step;
                m_w0[m_chan] = nib_edit(m_w0[m_chan], m_cur, 1'b0);
            end
            m_val = 1'b1; m_uchan = m_chan;
            m_uw1 = m_w1[m_chan]; m_uw0 = m_w0[m_chan];
        end else if (m_press[2]) begin
            m_cur = (m_cur + 1) % ND;
        end else if (m_press[3]) begin
            m_chan = (m_chan + 1) % NC;
        end
        if (!edit && upd_ready) m_val = 1'b0;
        // debounce: level accepted once seen unchanged for DEB samples
        np = 4'h0;
        for (int i = 0; i < 4; i++) begin
            m_run[i] = (m_s2[i] == m_last[i]) ? m_run[i] + 1 : 1;
            m_last[i] = m_s2[i];
            if (m_run[i] >= DEB && m_s2[i] != m_acc[i]) begin
                m_acc[i] = m_s2[i];
                if (!m_s2[i]) np[i] = 1'b1;
            end
        end
        m_press = np;
        m_s2 = m_s1;
        m_s1 = keys;
        m_n++;
    endtask

    // ------------------------------------------------------------------
    // Per-cycle compare, away from the active edge
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        logic [ND-1:0] esel, een;
        if (!rst_n) model_reset();
        esel = ND'(1) << m_cur;
        een  = ((m_n / BLK) % 2 == 1) ? ~esel : {ND{1'b1}};
        chk("freq_c1",  64'(freq1),  64'({m_w1[1], m_w1[0]}));
        chk("freq_c0",  64'(freq0),  64'({m_w0[1], m_w0[0]}));
        chk("act_c1",   64'(act1),   64'(m_w1[m_chan]));
        chk("act_c0",   64'(act0),   64'(m_w0[m_chan]));
        chk("chan_c1",  64'(chan1),  64'(m_chan));
        chk("chan_c0",  64'(chan0),  64'(m_chan));
        chk("dsel",     64'(dsel1),  64'(esel));
        chk("den",      64'(den1),   64'(een));
        chk("den_c0",   64'(den0),   64'(een));
        chk("uval_c1",  64'(uval1),  64'(m_val));
        chk("uval_c0",  64'(uval0),  64'(m_val));
        chk("uchan",    64'(uchan1), 64'(m_uchan));
        chk("uword_c1", 64'(uword1), 64'(m_uw1));
        chk("uword_c0", 64'(uword0), 64'(m_uw0));
        if (rst_n && uval1 && upd_ready) n_xfer++;
        if (rst_n) model_step();
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        keys = ~mask;
        tick(hold);
        keys = 4'hF;
        tick(10);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        keys = 4'hF; upd_ready = 1'b0; rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;

        // 1: reset state and blink
        chk("lit_freq_rst", 64'(freq1), 64'h0);
        chk("lit_dsel_rst", 64'(dsel1), 64'h01);
        chk("lit_uval_rst", 64'(uval1), 64'h0);
        tick(7);  chk("lit_den_7",  64'(den1), 64'h7F);
        tick(1);  chk("lit_den_8",  64'(den1), 64'h7E);
        tick(7);  chk("lit_den_15", 64'(den1), 64'h7E);
        tick(1);  chk("lit_den_16", 64'(den1), 64'h7F);

        // 2: short glitch ignored, long press accepted
        press(4'b0001, 3);
        chk("lit_glitch", 64'(act1), 64'h0);
        press(4'b0001, 10);
        chk("lit_inc1_word", 64'(act1), 64'h0000001);
        chk("lit_inc1_val",  64'(uval1), 64'h1);
        chk("lit_inc1_uw",   64'(uword1), 64'h1);
        chk("lit_inc1_uch",  64'(uchan1), 64'h0);

        // 3: cursor to digit 2, inc, then dec twice
        press(4'b0100, 10);
        press(4'b0100, 10);
        press(4'b0001, 10);
        chk("lit_0x101", 64'(act1), 64'h0000101);
        press(4'b0010, 10);
        press(4'b0010, 10);
        chk("lit_carry1", 64'(act1), 64'hFFFFF01);
        chk("lit_carry0", 64'(act0), 64'h0000F01);

        // 4: coalescing while not ready, then a single transfer
        do_reset();
        press(4'b0001, 10);
        press(4'b0001, 10);
        press(4'b0001, 10);
        chk("lit_coal_val", 64'(uval1), 64'h1);
        chk("lit_coal_uw",  64'(uword1), 64'h3);
        n_xfer = 0;
        upd_ready = 1'b1;
        tick(3);
        upd_ready = 1'b0;
        chk("lit_xfer_cnt", 64'(n_xfer), 64'h1);
        chk("lit_xfer_val", 64'(uval1), 64'h0);

        // 5: next channel then inc; cursor wraps after 7 lefts
        press(4'b1000, 10);
        press(4'b0001, 10);
        chk("lit_ch1_sel", 64'(chan1), 64'h1);
        chk("lit_ch1_hi",  64'(freq1[55:28]), 64'h1);
        chk("lit_ch1_lo",  64'(freq1[27:0]), 64'h3);
        chk("lit_ch1_uch", 64'(uchan1), 64'h1);
        for (int i = 0; i < 7; i++) press(4'b0100, 10);
        chk("lit_cur_wrap", 64'(dsel1), 64'h01);

        // edit wins over ready on the same edge, ready then clears it
        upd_ready = 1'b1;
        press(4'b0010, 10);
        chk("lit_ready_dec", 64'(freq1[55:28]), 64'h0);
        upd_ready = 1'b0;

        // 6: simultaneous inc+dec -> inc only; reset mid-handshake
        press(4'b0011, 10);
        chk("lit_prio", 64'(freq1[55:28]), 64'h1);
        chk("lit_prio_val", 64'(uval1), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("lit_rst_val",  64'(uval1), 64'h0);
        chk("lit_rst_freq", 64'(freq1), 64'h0);
        tick(2);
        rst_n = 1'b1;
        tick(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
